// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler:
// sequencer states, parity encodings and frame-length bounds.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } txState_t;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    localparam int DATA_BITS_SHORT = 7;
    localparam int DATA_BITS_LONG  = 8;
    localparam int MIN_FRAME_BITS  = 9;
    localparam int MAX_FRAME_BITS  = 12;

    function automatic logic parityEnabled(input logic [1:0] parityType);
        return (parityType == PAR_ODD) || (parityType == PAR_EVEN);
    endfunction

    // Bit 7 is excluded in 7-bit mode because it never reaches the line.
    function automatic logic parityBit(input logic [7:0] data,
                                       input logic       eightBits,
                                       input logic [1:0] parityType);
        logic [7:0] sent;
        sent = eightBits ? data : {1'b0, data[6:0]};
        return (^sent) ^ (parityType == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: first requesting index at or after the pointer wins;
// the pointer moves past the winner whenever a grant is taken.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    input  logic               Advance,
    output logic [NUM_REQ-1:0] Grant,
    output logic [IDX_W-1:0]   GrantIdx,
    output logic               AnyReq
);

    logic [IDX_W-1:0] pointer;
    logic [IDX_W-1:0] candIdx;

    always_comb begin
        // NOTE: every output gets a default before the search loop, so no path
        // leaves a value unassigned and no latch is inferred.
        Grant    = '0;
        GrantIdx = '0;
        AnyReq   = 1'b0;
        candIdx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            candIdx = IDX_W'((int'(pointer) + k) % NUM_REQ);
            if (!AnyReq && Req[candIdx]) begin
                AnyReq          = 1'b1;
                Grant[candIdx]  = 1'b1;
                GrantIdx        = candIdx;
            end
        end
    end

    always_ff @(posedge Clock) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (Reset) begin
            pointer <= '0;
        end else if (Advance) begin
            pointer <= (int'(GrantIdx) == NUM_REQ - 1) ? '0 : GrantIdx + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line between NUM_REQ byte sources: round-robin grant,
// then one start/data/parity/stop frame per grant, one bit per BaudTick.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 BaudTick,
    input  logic [NUM_REQ-1:0]   Req,
    input  logic [8*NUM_REQ-1:0] DataIn,
    input  logic [1:0]           ParityType,
    input  logic                 StopBits,
    input  logic                 DataLength,
    output logic [NUM_REQ-1:0]   Ack,
    output logic [IDX_W-1:0]     GrantId,
    output logic                 DataOut,
    output logic                 ActiveFlag,
    output logic                 DoneFlag
);

    txState_t         state;
    logic [7:0]       shiftReg;
    logic [2:0]       bitCnt;
    logic             dataLenLatched;
    logic             stopTwoLatched;
    logic             parityEnLatched;
    logic             parityBitLatched;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grantIdx;
    logic               anyReq;
    logic               arbFire;
    logic [7:0]         winnerByte;
    logic [2:0]         lastBit;

    // The DoneFlag cycle is skipped so back-to-back frames keep an idle bit.
    assign arbFire    = (state == IDLE) && !DoneFlag && !Reset && anyReq;
    assign Ack        = arbFire ? grant : '0;
    assign winnerByte = DataIn[8*int'(grantIdx) +: 8];
    assign lastBit    = dataLenLatched ? 3'(DATA_BITS_LONG - 1) : 3'(DATA_BITS_SHORT - 1);

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
        .Clock    (Clock),
        .Reset    (Reset),
        .Req      (Req),
        .Advance  (arbFire),
        .Grant    (grant),
        .GrantIdx (grantIdx),
        .AnyReq   (anyReq)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state            <= IDLE;
            DataOut          <= 1'b1;
            GrantId          <= '0;
            ActiveFlag       <= 1'b0;
            DoneFlag         <= 1'b0;
            bitCnt           <= '0;
            shiftReg         <= '0;
            dataLenLatched   <= 1'b0;
            stopTwoLatched   <= 1'b0;
            parityEnLatched  <= 1'b0;
            parityBitLatched <= 1'b0;
        end else begin
            DoneFlag <= 1'b0;
            case (state)
                IDLE: begin
                    if (arbFire) begin
                        GrantId          <= grantIdx;
                        shiftReg         <= winnerByte;
                        dataLenLatched   <= DataLength;
                        stopTwoLatched   <= StopBits;
                        parityEnLatched  <= parityEnabled(ParityType);
                        parityBitLatched <= parityBit(winnerByte, DataLength, ParityType);
                        bitCnt           <= '0;
                        ActiveFlag       <= 1'b1;
                        state            <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (BaudTick) begin
                        DataOut <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (BaudTick) begin
                        DataOut  <= shiftReg[0];
                        shiftReg <= {1'b0, shiftReg[7:1]};
                        bitCnt   <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (BaudTick) begin
                        if (bitCnt == lastBit) begin
                            bitCnt <= '0;
                            if (parityEnLatched) begin
                                DataOut <= parityBitLatched;
                                state   <= PARITY;
                            end else begin
                                DataOut <= 1'b1;
                                state   <= STOP1;
                            end
                        end else begin
                            DataOut  <= shiftReg[0];
                            shiftReg <= {1'b0, shiftReg[7:1]};
                            bitCnt   <= bitCnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (BaudTick) begin
                        DataOut <= 1'b1;
                        state   <= STOP1;
                    end
                end
                STOP1: begin
                    if (BaudTick) begin
                        if (stopTwoLatched) begin
                            state <= STOP2;
                        end else begin
                            DoneFlag   <= 1'b1;
                            ActiveFlag <= 1'b0;
                            DataOut    <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                STOP2: begin
                    if (BaudTick) begin
                        DoneFlag   <= 1'b1;
                        ActiveFlag <= 1'b0;
                        DataOut    <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    DataOut    <= 1'b1;
                    ActiveFlag <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected frames,
// a monitor captures Ack, GrantId and the serial bits and compares them.
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int IDX_W       = 2;
    localparam int TICK_PERIOD = 16;
    localparam int FRAME_BOUND = (MAX_FRAME_BITS + 3) * TICK_PERIOD * 2;

    logic                 Clock = 1'b0;
    logic                 Reset = 1'b1;
    logic                 BaudTick = 1'b0;
    logic [NUM_REQ-1:0]   Req = '0;
    logic [8*NUM_REQ-1:0] DataIn = '0;
    logic [1:0]           ParityType = PAR_NONE0;
    logic                 StopBits = 1'b0;
    logic                 DataLength = 1'b1;
    logic [NUM_REQ-1:0]   Ack;
    logic [IDX_W-1:0]     GrantId;
    logic                 DataOut;
    logic                 ActiveFlag;
    logic                 DoneFlag;

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .BaudTick   (BaudTick),
        .Req        (Req),
        .DataIn     (DataIn),
        .ParityType (ParityType),
        .StopBits   (StopBits),
        .DataLength (DataLength),
        .Ack        (Ack),
        .GrantId    (GrantId),
        .DataOut    (DataOut),
        .ActiveFlag (ActiveFlag),
        .DoneFlag   (DoneFlag)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int    id;
        string bits;
        bit    abort;
    } expFrame_t;

    expFrame_t expQ[$];
    int        vectors     = 0;
    int        miscompares = 0;
    bit        busy        = 1'b0;
    int        cyc         = 0;
    int        tickPhase   = 0;
    int        prevDoneCyc = -1;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkBits(input string name, input string actual, input string expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got \"%s\", expected \"%s\" (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Free-running baud enable: one cycle high every TICK_PERIOD cycles.
    initial begin : ticker
        forever begin
            @(posedge Clock);
            #1;
            cyc++;
            tickPhase = (tickPhase == TICK_PERIOD - 1) ? 0 : tickPhase + 1;
            BaudTick  = (tickPhase == 0);
        end
    end

    expFrame_t monExp;
    string     monBits;
    bit        monPending, monAborted, monDone;
    int        monIdx;

    initial begin : monitor
        forever begin
            @(negedge Clock);
            if (!Reset && DoneFlag) check("doneOutsideFrame", DoneFlag, 0);
            if (!Reset && Ack != '0) begin
                busy   = 1'b1;
                monIdx = -1;
                for (int k = 0; k < NUM_REQ; k++) if (Ack[k]) monIdx = k;
                check("ackOneHot", $countones(Ack), 1);
                check("ackWhileIdle", ActiveFlag, 0);
                if (expQ.size() == 0) begin
                    check("unexpectedAck", monIdx, -1);
                end else begin
                    monExp = expQ.pop_front();
                    check("ackIndex", monIdx, monExp.id);
                    monBits    = "";
                    monPending = 1'b0;
                    monAborted = 1'b0;
                    monDone    = 1'b0;
                    for (int c = 0; c < FRAME_BOUND && !monDone && !monAborted; c++) begin
                        @(negedge Clock);
                        if (Reset) begin
                            monAborted = 1'b1;
                        end else begin
                            if (c == 0) begin
                                check("activeAfterGrant", ActiveFlag, 1);
                                check("grantId", GrantId, monExp.id);
                            end
                            if (Ack != '0) check("ackDuringFrame", Ack, 0);
                            if (monPending) begin
                                if (DoneFlag) begin
                                    monDone = 1'b1;
                                end else begin
                                    monBits = {monBits, DataOut ? "1" : "0"};
                                    if (monBits.len() == 1 && prevDoneCyc >= 0)
                                        check("idleGapAtLeastOneBit", (cyc - prevDoneCyc) >= TICK_PERIOD, 1);
                                end
                            end else if (DoneFlag) begin
                                check("doneWithoutTick", DoneFlag, 0);
                                monDone = 1'b1;
                            end
                            monPending = BaudTick;
                        end
                    end
                    if (monAborted) begin
                        check("resetAbortExpected", monExp.abort, 1);
                        prevDoneCyc = -1;
                    end else if (!monDone) begin
                        check("frameTimeout", 0, 1);
                    end else begin
                        checkBits("frameBits", monBits, monExp.bits);
                        check("frameLenInRange",
                              monBits.len() >= MIN_FRAME_BITS && monBits.len() <= MAX_FRAME_BITS, 1);
                        check("activeClearedAtDone", ActiveFlag, 0);
                        check("lineHighAtDone", DataOut, 1);
                        if (Ack != '0) check("ackInDoneCycle", Ack, 0);
                        prevDoneCyc = cyc;
                    end
                end
                busy = 1'b0;
            end
        end
    end

    task automatic pushExp(input int id, input string bits, input bit abort);
        expFrame_t e;
        e.id = id; e.bits = bits; e.abort = abort;
        expQ.push_back(e);
    endtask

    task automatic setSlot(input int idx, input logic [7:0] val);
        DataIn[8*idx +: 8] = val;
    endtask

    task automatic setCfg(input logic [1:0] par, input logic stop2, input logic len8);
        ParityType = par;
        StopBits   = stop2;
        DataLength = len8;
    endtask

    task automatic waitAck(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge Clock);
            if (Ack != '0) got = 1'b1;
        end
    endtask

    // Raise one request, hold it until its Ack, drop it after the grant edge.
    task automatic requestOne(input int idx);
        bit got;
        Req[idx] = 1'b1;
        waitAck(300, got);
        check("ackSeen", got, 1);
        @(posedge Clock);
        #1;
        Req[idx] = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 4000 && (expQ.size() != 0 || busy); i++) @(posedge Clock);
        check("scoreboardDrained", expQ.size() + int'(busy), 0);
        repeat (4) @(posedge Clock);
        #2;
    endtask

    task automatic pulseReset();
        @(posedge Clock); #2;
        Reset = 1'b1;
        @(posedge Clock); #2;
        Reset = 1'b0;
    endtask

    initial begin : stimulus
        bit got;
        int nAck;
        int nTick;

        // Requests held during reset must not be acknowledged.
        Req = '1;
        repeat (3) @(posedge Clock);
        #2;
        check("rstDataOut", DataOut, 1);
        check("rstAck", Ack, 0);
        check("rstGrantId", GrantId, 0);
        check("rstActive", ActiveFlag, 0);
        check("rstDone", DoneFlag, 0);
        Req   = '0;
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #2;

        // 0xA5, 8 data bits, no parity (11 encoding), one stop bit.
        setSlot(0, 8'hA5);
        setCfg(PAR_NONE3, 1'b0, 1'b1);
        pushExp(0, "0101001011", 1'b0);
        requestOne(0);
        waitIdle();

        // 0x03, 8 bits, even parity, two stop bits.
        setSlot(2, 8'h03);
        setCfg(PAR_EVEN, 1'b1, 1'b1);
        pushExp(2, "011000000011", 1'b0);
        requestOne(2);
        waitIdle();

        // 7 bits, odd parity: 0x7F and 0xFF give the same frame.
        setSlot(1, 8'h7F);
        setCfg(PAR_ODD, 1'b0, 1'b0);
        pushExp(1, "0111111101", 1'b0);
        requestOne(1);
        waitIdle();
        setSlot(1, 8'hFF);
        pushExp(1, "0111111101", 1'b0);
        requestOne(1);
        waitIdle();

        // Pointer back to 0, then all four requesters held for five frames.
        pulseReset();
        setSlot(0, 8'h11); setSlot(1, 8'h22); setSlot(2, 8'h44); setSlot(3, 8'h88);
        setCfg(PAR_NONE0, 1'b0, 1'b1);
        pushExp(0, "0100010001", 1'b0);
        pushExp(1, "0010001001", 1'b0);
        pushExp(2, "0001000101", 1'b0);
        pushExp(3, "0000100011", 1'b0);
        pushExp(0, "0100010001", 1'b0);
        Req  = '1;
        nAck = 0;
        for (int i = 0; i < 4000 && nAck < 5; i++) begin
            @(negedge Clock);
            if (Ack != '0) nAck++;
        end
        check("fiveAcks", nAck, 5);
        @(posedge Clock); #1;
        Req = '0;
        waitIdle();

        // Reset while DATA bit 3 (a 0 for 0xA5) is on the line.
        setSlot(2, 8'hA5);
        pushExp(2, "", 1'b1);
        requestOne(2);
        nTick = 0;
        for (int i = 0; i < 200 && nTick < 5; i++) begin
            @(negedge Clock);
            if (BaudTick) nTick++;
        end
        check("ticksToBit3", nTick, 5);
        repeat (3) @(posedge Clock);
        #2;
        check("lineAtBit3", DataOut, 0);
        check("activeAtBit3", ActiveFlag, 1);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("abortLineHigh", DataOut, 1);
        check("abortActiveLow", ActiveFlag, 0);
        check("abortNoDone", DoneFlag, 0);
        #1;
        Reset = 1'b0;
        repeat (40) @(posedge Clock);
        #2;

        // Pointer restarts at 0: with 1 and 3 requesting, 1 wins first.
        setSlot(1, 8'h22); setSlot(3, 8'h88);
        pushExp(1, "0010001001", 1'b0);
        pushExp(3, "0000100011", 1'b0);
        Req = 4'b1010;
        waitAck(300, got);
        check("postResetAck1", got, 1);
        @(posedge Clock); #1;
        Req[1] = 1'b0;
        waitAck(600, got);
        check("postResetAck2", got, 1);
        @(posedge Clock); #1;
        Req[3] = 1'b0;
        waitIdle();

        // Grant lands on a tick; config is changed right after the grant.
        setSlot(0, 8'h01);
        setCfg(PAR_EVEN, 1'b1, 1'b1);
        pushExp(0, "010000000111", 1'b0);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge Clock);
            #2;
            got = BaudTick;
        end
        check("tickAligned", got, 1);
        Req[0] = 1'b1;
        @(negedge Clock);
        check("ackOnTickCycle", Ack, 1);
        @(posedge Clock); #1;
        Req[0] = 1'b0;
        setCfg(PAR_ODD, 1'b0, 1'b0);
        repeat (8) @(posedge Clock);
        #1;
        check("startWaitsNextTick", DataOut, 1);
        check("activeWhileWaiting", ActiveFlag, 1);
        waitIdle();

        check("queueEmptyAtEnd", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Transmit-side controller that shares one UART serial line between NUM_REQ byte requesters.
- Round-robin arbitration between requesters.
- Latches the winner's byte and the line configuration.
- Serialises one frame per grant (start, data LSB first, optional parity, 1 or 2 stop bits), one bit per BaudTick.
- Sits between the host-side byte sources and the TX pin; replaces free-running shift sequencing with an explicit grant/done handshake.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
IDX_W, $clog2(NUM_REQ), width of the grant index (derived, not overridden).

Ports:
Clock  in  1  system clock; all logic on rising edge.
Reset  in  1  synchronous, active-high reset.
BaudTick  in  1  one-Clock-cycle enable, one per bit period.
Req  in  NUM_REQ  per-requester request; level, held until Ack.
DataIn  in  8*NUM_REQ  requester i byte at [8i+7:8i]; sampled only in the grant cycle.
ParityType  in  2  01 odd, 10 even, 00/11 no parity bit.
StopBits  in  1  0: one stop bit, 1: two stop bits.
DataLength  in  1  0: 7 data bits (DataIn[6:0]), 1: 8 data bits.
Ack  out  NUM_REQ  one-hot, single-cycle pulse to the granted requester.
GrantId  out  IDX_W  index of requester owning the current frame; valid while ActiveFlag.
DataOut  out  1  serial line; idle high.
ActiveFlag  out  1  high from grant cycle through end of last stop bit.
DoneFlag  out  1  single-cycle pulse when a frame's last stop bit period ends.

Behaviour:
- Reset values: DataOut=1, Ack=0, GrantId=0, ActiveFlag=0, DoneFlag=0, state IDLE, RR pointer=0, bit counter=0.
- Reset is effective in any state, including mid-frame: line returns high next cycle, frame abandoned, no DoneFlag.
- States: IDLE, WAIT_TICK, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - If any Req bit is high, grant the first requesting index at or after the RR pointer, wrapping modulo NUM_REQ.
  - Same cycle: pulse Ack[winner], set GrantId, latch DataIn slice, ParityType, StopBits, DataLength.
  - Next cycle: ActiveFlag=1, go to WAIT_TICK.
  - RR pointer becomes winner+1 mod NUM_REQ.
- A BaudTick coinciding with the grant cycle is not used. WAIT_TICK waits for the next BaudTick.
- Each BaudTick drives the next bit on DataOut (registered; changes the cycle after the tick). Each bit is held until the following tick. Sequence:
  - WAIT_TICK -> START: DataOut=0.
  - START -> DATA: bit 0, LSB first.
  - DATA: counter 0..6 or 0..7 per latched DataLength; after the last bit -> PARITY if parity enabled, else STOP1.
  - PARITY: bit = XOR of the transmitted data bits; inverted for odd parity.
  - STOP1 (DataOut=1) -> STOP2 if StopBits=1, else end.
  - End = the tick that closes the last stop bit: DoneFlag=1 for one cycle, ActiveFlag=0, DataOut stays 1, state IDLE.
- Frame length 9..12 bit periods. First arbitration after DoneFlag happens the cycle after DoneFlag, so back-to-back frames carry at least one full idle-high bit period.
- Config inputs and Req changes mid-frame are ignored; the latched copies rule.
- A requester dropping Req after Ack has no effect.
- Parity with 7-bit length covers bits [6:0] only. DataIn[7] is ignored.
- Ack is never asserted while ActiveFlag=1. At most one Ack bit is high per cycle.

Decomposition:
- Shared package uart_pkg:
  - State enum.
  - Parity encodings PAR_NONE0=00, PAR_ODD=01, PAR_EVEN=10, PAR_NONE3=11.
  - Frame-length constants.
- One natural sub-module: uart_rr_arbiter (Req, pointer -> one-hot grant + index), combinational plus pointer register.
- The frame sequencer stays in the top.

Test Plan:
- Req[0]=1, DataIn[7:0]=0xA5, 8N1, BaudTick every 16 cycles -> Ack[0] one pulse; DataOut per tick 0,1,0,1,0,0,1,0,1,1; DoneFlag once after 10 periods.
- Req[2], 0x03, 8 bits, even parity, two stop bits -> 0,1,1,0,0,0,0,0,0, parity 0, 1,1; 12 periods; GrantId=2.
- Req[1], 0x7F, 7 bits, odd parity, one stop bit -> seven 1s data, parity 0, stop 1; 10 periods total. Repeat with 0xFF: bit7 not sent, same parity.
- All four Req held high for five frames -> Ack order 0,1,2,3,0. Each gap from DoneFlag to next start bit is at least one bit period.
- Reset asserted during DATA bit 3 -> next cycle DataOut=1, ActiveFlag=0, no DoneFlag. With Req[3]=1 after release -> grant to 3 only after Req[0..2] are checked from pointer 0.
- BaudTick coincident with the grant cycle, and ParityType/StopBits toggled mid-frame -> start bit delayed to the next tick; frame format matches the configuration latched at grant.
